// File: rtl/serial_sched_pkg.sv
// Shared definitions for the serial shift-engine scheduler: FSM state
// encoding, the START fault limit and a width helper for the counters.
package serial_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_LOAD,
        ST_START,
        ST_SHIFT,
        ST_GUARD
    } state_t;

    // Cycles ser_ready may stay high in START before the transfer is abandoned.
    localparam int unsigned START_FAULT_CYC = 2;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sched_tick_div.sv
// Bit-tick divider: one tick every DIV enabled cycles, restarted by clr.
// A down-counter from DIV-1 with terminal count at zero.
module serial_sched_tick_div
    import serial_sched_pkg::*;
#(
    parameter int unsigned DIV = 50
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = cnt_w(DIV);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            cnt <= W'(DIV - 1);
        end else if (clr) begin
            cnt <= W'(DIV - 1);
        end else if (en) begin
            cnt <= (cnt == '0) ? W'(DIV - 1) : cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/serial_sched.sv
// Round-robin scheduler sharing one serial shift engine among NREQ requesters.
// Define SERIAL_SCHED_PRIO_EN to give req[0] fixed highest priority.
//
// state  | meaning
// IDLE   | no transfer, waiting for any req
// ARB    | pick requester, select it, latch its word
// LOAD   | ser_trig pulse to the engine
// START  | wait for the engine to drop ser_ready
// SHIFT  | WIDTH ticks until ser_ready returns
// GUARD  | cs_n released, GAP ticks before the next arbitration
module serial_sched
    import serial_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DIV   = 50,
    parameter int unsigned GAP   = 2
) (
    input  logic                    CLKB,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    busy,
    output logic [NREQ-1:0]         cs_n,
    output logic                    ser_rst,
    output logic                    ser_trig,
    output logic [WIDTH-1:0]        ser_data_in,
    input  logic [WIDTH-1:0]        ser_data_out,
    input  logic                    ser_ready,
    output logic                    ser_tick
);

    localparam int unsigned IW  = cnt_w(NREQ);
    localparam int unsigned IW1 = IW + 1;
    localparam int unsigned GW  = cnt_w(GAP);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   ptr_next;
    logic [IW-1:0]   arb_idx;
    logic            arb_vld;
    logic [IW:0]     pos;
    logic [NREQ-1:0] req_m;
    logic [WIDTH-1:0] sel_word;
    logic [GW-1:0]   gap_cnt;
    logic [1:0]      start_cnt;
    logic            tick_en;
    logic            tick_clr;

    assign ser_rst  = ~RST;
    // START is included so the first tick lands exactly DIV cycles after ser_trig.
    assign tick_en  = (state == ST_START) || (state == ST_SHIFT) || (state == ST_GUARD);
    assign tick_clr = (state == ST_LOAD);
    assign ptr_next = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;

    serial_sched_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk_sys (CLKB),
        .rst_b   (RST),
        .clr     (tick_clr),
        .en      (tick_en),
        .tick    (ser_tick)
    );

    always_comb begin
        req_m   = req;
        arb_idx = '0;
        arb_vld = 1'b0;
        pos     = '0;
`ifdef SERIAL_SCHED_PRIO_EN
        req_m[0] = 1'b0;
`endif
        // Scan from farthest to nearest so the first set bit at/after ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + IW1'(k);
            if (pos >= IW1'(NREQ)) begin
                pos = pos - IW1'(NREQ);
            end
            if (req_m[pos[IW-1:0]]) begin
                arb_idx = pos[IW-1:0];
                arb_vld = 1'b1;
            end
        end
`ifdef SERIAL_SCHED_PRIO_EN
        if (req[0]) begin
            arb_idx = '0;
            arb_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_word = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLKB) begin
        if (!RST) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            done        <= '0;
            busy        <= 1'b0;
            cs_n        <= '1;
            ser_trig    <= 1'b0;
            rd_data     <= '0;
            ser_data_in <= '0;
            gap_cnt     <= '0;
            start_cnt   <= '0;
        end else begin
            done     <= '0;
            ser_trig <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (arb_vld) begin
                        gnt         <= arb_idx;
                        cs_n        <= ~(NREQ'(1) << arb_idx);
                        ser_data_in <= sel_word;
                        busy        <= 1'b1;
                        ser_trig    <= 1'b1;
                        state       <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    start_cnt <= '0;
                    state     <= ST_START;
                end
                ST_START: begin
                    if (!ser_ready) begin
                        state <= ST_SHIFT;
                    end else if (start_cnt == 2'(START_FAULT_CYC)) begin
                        busy  <= 1'b0;
                        cs_n  <= '1;
                        state <= ST_IDLE;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        rd_data <= ser_data_out;
                        done    <= NREQ'(1) << gnt;
                        cs_n    <= '1;
                        gap_cnt <= GW'(GAP - 1);
                        state   <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (ser_tick) begin
                        if (gap_cnt == '0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
`ifdef SERIAL_SCHED_PRIO_EN
                            // A priority win must not disturb the rotation of the others.
                            if (gnt != '0) begin
                                ptr <= ptr_next;
                            end
`else
                            ptr <= ptr_next;
`endif
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    start_stuck: assert property (@(posedge CLKB) disable iff (!RST)
        !((state == ST_START) && ser_ready && (start_cnt == 2'(START_FAULT_CYC))));

endmodule
